// File: rtl/enc_pkg.sv
// Shared definitions for the Pmod ENC quadrature generator: direction codes,
// the Gray phase table and the request state machine encoding.
package enc_pkg;

    localparam logic DIR_A_LEAD = 1'b0;
    localparam logic DIR_B_LEAD = 1'b1;

    // {A,B} per phase index. A-lead walks upward through the table, B-lead walks downward.
    localparam logic [1:0] PHASE_TAB [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EDGE,
        FINISH
    } state_t;

endpackage

// File: rtl/enc_bounce_gen.sv
// Contact-bounce shaper for one encoder channel. When the target changes, the line
// toggles 2*BOUNCE_N+1 times, BOUNCE_CYCLES apart. settled marks the cycle before the final toggle.
module enc_bounce_gen #(
    parameter int BOUNCE_CYCLES = 20,
    parameter int BOUNCE_N      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic target,
    input  logic edge_stb,
    output logic line,
    output logic settled
);

    localparam int CW = (BOUNCE_CYCLES > 2) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int NW = (BOUNCE_N > 0) ? $clog2(2 * BOUNCE_N + 1) : 1;
    localparam logic [CW-1:0] C_LOAD = CW'(BOUNCE_CYCLES - 1);
    localparam logic [NW-1:0] N_LOAD = NW'(2 * BOUNCE_N);

    logic          line_q, line_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [NW-1:0] left_q, left_d;

    always_comb begin
        line_d  = line_q;
        tmr_d   = tmr_q;
        left_d  = left_q;
        settled = 1'b0;
        if (edge_stb && (target != line_q)) begin
            line_d  = ~line_q;
            tmr_d   = C_LOAD;
            left_d  = N_LOAD;
            settled = (BOUNCE_N == 0);
        end else if (left_q != '0) begin
            if (tmr_q == '0) begin
                line_d  = ~line_q;
                tmr_d   = C_LOAD;
                left_d  = left_q - 1'b1;
                settled = (left_q == NW'(1));
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= 1'b1;
            tmr_q  <= '0;
            left_q <= '0;
        end else begin
            line_q <= line_d;
            tmr_q  <= tmr_d;
            left_q <= left_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/enc_quad_gen.sv
// Pmod ENC shaft emulator: turns detent-step requests into registered A/B quadrature
// and tracks a signed detent position. Define ENC_QGEN_BOUNCE_EN to add contact bounce.
module enc_quad_gen
    import enc_pkg::*;
#(
    parameter int STEP_CYCLES   = 1000,
    parameter int BOUNCE_CYCLES = 20,
    parameter int BOUNCE_N      = 3,
    parameter int POS_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_dir,
    input  logic [7:0]              req_count,
    output logic                    busy,
    output logic                    done,
    output logic                    A,
    output logic                    B,
    output logic signed [POS_W-1:0] pos
);

    localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    // WAIT lasts STEP_CYCLES-1 cycles and EDGE one, which keeps edges on the step grid.
    localparam logic [TW-1:0] T_LOAD = TW'(STEP_CYCLES - 2);

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [9:0]              edges_q, edges_d;
    logic [1:0]              phase_q, phase_d;
    logic                    dir_q, dir_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic [1:0]              ab_d;
    logic                    edge_go;
    logic                    detent_done;

`ifdef ENC_QGEN_BOUNCE_EN
    logic settle_a, settle_b, settle_q;

    enc_bounce_gen #(.BOUNCE_CYCLES(BOUNCE_CYCLES), .BOUNCE_N(BOUNCE_N)) u_bounce_a (
        .clk(clk), .rst(rst), .target(ab_d[1]), .edge_stb(edge_go), .line(A), .settled(settle_a)
    );
    enc_bounce_gen #(.BOUNCE_CYCLES(BOUNCE_CYCLES), .BOUNCE_N(BOUNCE_N)) u_bounce_b (
        .clk(clk), .rst(rst), .target(ab_d[0]), .edge_stb(edge_go), .line(B), .settled(settle_b)
    );

    // Position follows the settled edge; the phase index already holds the new value by then.
    assign detent_done = (settle_a | settle_b) && (phase_q == 2'd0);
`else
    logic a_q, b_q;

    assign A           = a_q;
    assign B           = b_q;
    assign detent_done = edge_go && (phase_d == 2'd0);
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        edges_d = edges_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        edge_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    dir_d   = req_dir;
                    edges_d = {req_count, 2'b00};
                    timer_d = T_LOAD;
                    state_d = (req_count != 8'd0) ? WAIT : FINISH;
                end
            end
            WAIT: begin
                if (edges_q == 10'd0) begin
`ifdef ENC_QGEN_BOUNCE_EN
                    if (settle_q) state_d = FINISH;
`else
                    state_d = FINISH;
`endif
                end else if (timer_q == '0) begin
                    edge_go = 1'b1;
                    edges_d = edges_q - 10'd1;
                    phase_d = (dir_q == DIR_B_LEAD) ? phase_q - 2'd1 : phase_q + 2'd1;
                    state_d = EDGE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            EDGE: begin
                timer_d = T_LOAD;
`ifdef ENC_QGEN_BOUNCE_EN
                state_d = (edges_q == 10'd0 && settle_q) ? FINISH : WAIT;
`else
                state_d = (edges_q != 10'd0) ? WAIT : FINISH;
`endif
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ab_d    = PHASE_TAB[phase_d];
        pos_d   = pos_q;
        if (detent_done)
            pos_d = (dir_q == DIR_A_LEAD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
        ready_d = (state_d == IDLE);
    end

    // NOTE: every flop is updated with <= so all next-state values are computed from the
    // same pre-edge state; a blocking write here would leak new values into later reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            edges_q  <= '0;
            phase_q  <= 2'd0;
            dir_q    <= DIR_A_LEAD;
            pos_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef ENC_QGEN_BOUNCE_EN
            settle_q <= 1'b0;
`else
            a_q      <= 1'b1;
            b_q      <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            edges_q  <= edges_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef ENC_QGEN_BOUNCE_EN
            settle_q <= settle_a | settle_b;
`else
            a_q      <= ab_d[1];
            b_q      <= ab_d[0];
`endif
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pos       = pos_q;

endmodule
